// File: rtl/udl_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
package udl_pkg;

  typedef enum logic [1:0] {UDL_HOLD, UDL_LOAD, UDL_UP, UDL_DOWN} udl_op_t;

  // Next in-range value of a modulo-mod counter. The wrap compare is done before
  // any arithmetic, so q+1 never overflows past the wrap point.
  function automatic int unsigned udl_wrap_next(input int unsigned q, input logic up,
                                                input int unsigned mod);
    if (up) return (q >= mod - 32'd1) ? 32'd0 : q + 32'd1;
    else    return (q == 32'd0 || q >= mod) ? mod - 32'd1 : q - 32'd1;
  endfunction

endpackage

// File: rtl/udl_mod_counter_if.sv
// Control/data bundle of one counter stage. With UDL_MATCH_EN defined it also
// carries the compare value and the match pulse.
interface udl_mod_counter_if #(parameter int BITS = 6);
  logic            enable;
  logic            up;
  logic            load;
  logic [BITS-1:0] D;
  logic [BITS-1:0] Q;
  logic            co;
  logic            load_err;
`ifdef UDL_MATCH_EN
  logic [BITS-1:0] cmp;
  logic            hit;

  modport master (output enable, up, load, D, cmp, input Q, co, load_err, hit);
  modport slave  (input enable, up, load, D, cmp, output Q, co, load_err, hit);
`else
  modport master (output enable, up, load, D, input Q, co, load_err);
  modport slave  (input enable, up, load, D, output Q, co, load_err);
`endif
endinterface

// File: rtl/udl_mod_next.sv
// Combinational next-count and wrap-point detect for one counting step.
module udl_mod_next
  import udl_pkg::*;
#(
  parameter int BITS = 6,
  parameter int MOD  = 60
) (
  input  logic [BITS-1:0] q,
  input  logic            up,
  output logic [BITS-1:0] q_next,
  output logic            at_wrap
);

  localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);

  assign at_wrap = up ? (q == MAX) : (q == '0);
  assign q_next  = BITS'(udl_wrap_next(32'(q), up, 32'(MOD)));

endmodule

// File: rtl/udl_mod_counter.sv
// Modulo-MOD up/down counter with clamped load, load_err pulse and cascade carry.
// Optional feature: define UDL_MATCH_EN for the cmp input and registered hit pulse.
module udl_mod_counter
  import udl_pkg::*;
#(
  parameter int BITS = 6,
  parameter int MOD  = 60
) (
  input logic              clk,
  input logic              reset,
  udl_mod_counter_if.slave bus
);

  localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);

  if (MOD < 2 || MOD > (1 << BITS)) begin : g_bad_mod
    $error("udl_mod_counter: MOD must satisfy 2 <= MOD <= 2**BITS");
  end

  udl_op_t         op;
  logic [BITS-1:0] q_r, q_d, q_next;
  logic            at_wrap, err_r, err_d;

  udl_mod_next #(.BITS(BITS), .MOD(MOD)) u_next (
    .q      (q_r),
    .up     (bus.up),
    .q_next (q_next),
    .at_wrap(at_wrap)
  );

  always_comb begin
    op = UDL_HOLD;
    if (bus.load)        op = UDL_LOAD;
    else if (bus.enable) op = bus.up ? UDL_UP : UDL_DOWN;
  end

  // Out-of-range loads clamp to the top of the range so Q stays within 0..MOD-1.
  always_comb begin
    q_d   = q_r;
    err_d = 1'b0;
    case (op)
      UDL_LOAD: begin
        if (bus.D > MAX) begin
          q_d   = MAX;
          err_d = 1'b1;
        end else begin
          q_d = bus.D;
        end
      end
      UDL_UP, UDL_DOWN: q_d = q_next;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_d;
      err_r <= err_d;
    end
  end

  assign bus.Q        = q_r;
  assign bus.load_err = err_r;
  // Zero-latency carry so the next cascaded stage steps on the same edge.
  assign bus.co       = bus.enable & ~bus.load & at_wrap;

`ifdef UDL_MATCH_EN
  logic hit_r;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hit_r <= 1'b0;
    else        hit_r <= (op == UDL_UP || op == UDL_DOWN) && (q_next == bus.cmp);
  end
  assign bus.hit = hit_r;
`endif

endmodule

// File: tb/tb_udl_mod_counter.sv
// Bench for udl_mod_counter: seconds stage cascaded into a minutes stage (both MOD=60).
module tb_udl_mod_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udl_mod_counter_if #(.BITS(6)) sif ();
  udl_mod_counter_if #(.BITS(6)) mif ();

  udl_mod_counter #(.BITS(6), .MOD(60)) u_sec (.clk(clk), .reset(reset), .bus(sif));
  udl_mod_counter #(.BITS(6), .MOD(60)) u_min (.clk(clk), .reset(reset), .bus(mif));

  assign mif.enable = sif.co;
  assign mif.up     = sif.up;

  logic [5:0] cmp_val;
`ifdef UDL_MATCH_EN
  assign sif.cmp = cmp_val;
  assign mif.cmp = 6'd63;
`endif

  int checks = 0;
  int errors = 0;
  int mq;       // reference count of the seconds stage
  int co_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs to the seconds stage and check it against the model.
  task automatic step(input logic ld, input logic en, input logic u, input logic [5:0] d,
                      input string tag);
    int exp_err, exp_hit;
    sif.load = ld; sif.enable = en; sif.up = u; sif.D = d;
    #1;
    co_seen = int'(sif.co);
    chk({tag, " co"}, co_seen, int'(en && !ld && ((u && mq == 59) || (!u && mq == 0))));
    exp_err = 0;
    exp_hit = 0;
    if (ld) begin
      exp_err = (d >= 60) ? 1 : 0;
      mq      = exp_err ? 59 : int'(d);
    end else if (en) begin
      mq      = u ? (mq + 1) % 60 : (mq + 59) % 60;
      exp_hit = (mq == int'(cmp_val)) ? 1 : 0;
    end
    @(posedge clk); #1;
    chk({tag, " Q"}, int'(sif.Q), mq);
    chk({tag, " load_err"}, int'(sif.load_err), exp_err);
`ifdef UDL_MATCH_EN
    chk({tag, " hit"}, int'(sif.hit), exp_hit);
`endif
  endtask

  typedef struct {
    logic ld, en, u;
    logic [5:0] d;
    logic [5:0] q;
    logic co, err;
    string tag;
  } vec_t;
  vec_t tbl[$];

  initial begin
    tbl.push_back('{1'b1, 1'b0, 1'b1, 6'd58, 6'd58, 1'b0, 1'b0, "up load58"});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 6'd0,  6'd59, 1'b0, 1'b0, "up 58->59"});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 6'd0,  6'd0,  1'b1, 1'b0, "up wrap"});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 6'd0,  6'd1,  1'b0, 1'b0, "up 0->1"});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 6'd1,  6'd1,  1'b0, 1'b0, "dn load1"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6'd0,  6'd0,  1'b0, 1'b0, "dn 1->0"});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 6'd0,  6'd59, 1'b1, 1'b0, "dn wrap"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 6'd63, 6'd59, 1'b0, 1'b1, "load63"});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 6'd0,  6'd59, 1'b0, 1'b0, "err clears"});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 6'd10, 6'd10, 1'b0, 1'b0, "load over en"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 6'd59, 6'd59, 1'b0, 1'b0, "load59 ok"});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 6'd60, 6'd59, 1'b0, 1'b1, "load60 err"});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 6'd0,  6'd59, 1'b0, 1'b0, "hold"});

    reset = 1'b0;
    sif.enable = 1'b1; sif.up = 1'b0; sif.load = 1'b0; sif.D = '0;
    mif.load = 1'b0; mif.D = '0;
    cmp_val = 6'd63;
    mq = 0;

    // Reset held with enable high: Q stays 0; co follows enable & ~up at Q=0.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst Q", int'(sif.Q), 0);
      chk("rst load_err", int'(sif.load_err), 0);
    end
    chk("rst co down", int'(sif.co), 1);
    sif.up = 1'b1;
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 6'd0, "post rst");
      chk("post rst Q table", int'(sif.Q), i);
    end

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].en, tbl[i].u, tbl[i].d, tbl[i].tag);
      chk({tbl[i].tag, " tbl Q"}, int'(sif.Q), int'(tbl[i].q));
      chk({tbl[i].tag, " tbl co"}, co_seen, int'(tbl[i].co));
      chk({tbl[i].tag, " tbl err"}, int'(sif.load_err), int'(tbl[i].err));
    end

    // Cascade: both at 59, one enable rolls both to 0 on the same edge.
    mif.load = 1'b1; mif.D = 6'd59;
    step(1'b1, 1'b0, 1'b1, 6'd59, "cas load");
    chk("cas min loaded", int'(mif.Q), 59);
    mif.load = 1'b0;
    sif.load = 1'b0; sif.enable = 1'b1; sif.up = 1'b1;
    #1;
    chk("cas min co", int'(mif.co), 1);
    step(1'b0, 1'b1, 1'b1, 6'd0, "cas step");
    chk("cas sec Q", int'(sif.Q), 0);
    chk("cas min Q", int'(mif.Q), 0);

    // Asynchronous reset mid-count clears without a clock edge.
    step(1'b1, 1'b0, 1'b1, 6'd63, "pre arst");
    reset = 1'b0;
    #2;
    chk("arst Q", int'(sif.Q), 0);
    chk("arst load_err", int'(sif.load_err), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mq = 0;
    step(1'b0, 1'b1, 1'b1, 6'd0, "resume");

`ifdef UDL_MATCH_EN
    cmp_val = 6'd5;
    step(1'b1, 1'b0, 1'b1, 6'd3, "m load3");
    step(1'b0, 1'b1, 1'b1, 6'd0, "m to4");
    step(1'b0, 1'b1, 1'b1, 6'd0, "m to5");
    chk("m hit at5", int'(sif.hit), 1);
    step(1'b0, 1'b1, 1'b1, 6'd0, "m to6");
    step(1'b1, 1'b0, 1'b1, 6'd5, "m load5");
    chk("m load5 no hit", int'(sif.hit), 0);
    cmp_val = 6'd61;
    for (int i = 0; i < 62; i++) step(1'b0, 1'b1, 1'b1, 6'd0, "m cmp61");
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cmp_val = 6'($urandom_range(0, 63));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
